shared_event_fifo: RTL and testbench
====================================

SHARED_EVENT_FIFO -- requirements
Module: shared_event_fifo

Interface
REQ-001 Parameter WIDTH, default 64, packet width in bits (no start/stop bits).
REQ-002 Parameter FIFO_BITS, default 11, log2 of depth; DEPTH = 2**FIFO_BITS = 2048.
REQ-003 The block SHALL have exactly one clock; reset SHALL be synchronous and active-low; there SHALL be no asynchronous reset path.
REQ-004 clk  input  1  master clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 input_event  input  WIDTH  packet to store; sampled when write_fifo_n is low.
REQ-007 write_fifo_n  input  1  active-low push request.
REQ-008 read_fifo_n  input  1  active-low request to present the head entry on tx_data without removing it.
REQ-009 fifo_ack  input  1  active-high pop; the head entry is consumed.
REQ-010 tx_data  output  WIDTH  registered copy of the head entry.
REQ-011 fifo_full  output  1  high when occupancy == DEPTH.
REQ-012 fifo_half  output  1  high when occupancy >= DEPTH/2.
REQ-013 fifo_empty  output  1  high when occupancy == 0.
REQ-014 fifo_counter  output  FIFO_BITS+1  current occupancy, 0..DEPTH.
REQ-015 fifo_overflow  output  1  sticky: a push was attempted while full.

Function
REQ-016 Push: write_fifo_n low and fifo_full low at edge -> store input_event at the write pointer; write pointer +1 modulo DEPTH.
REQ-017 Push while full -> data dropped; pointers and count unchanged; fifo_overflow set to 1 and held until reset.
REQ-018 Peek: read_fifo_n low and fifo_empty low -> tx_data = the entry at the read pointer, one cycle later; the pointer is not moved.
REQ-019 Peek while empty -> tx_data holds its previous value.
REQ-020 Pop: fifo_ack high and fifo_empty low -> read pointer +1 modulo DEPTH.
REQ-021 Pop while empty -> ignored; no underflow, and the counter stays 0.
REQ-022 Push and pop in the same edge (not full, not empty) -> count unchanged; both pointers advance.
REQ-023 Push and pop in the same edge when full -> the pop is accepted and the push is dropped; count = DEPTH-1; overflow set.
REQ-024 Push and pop in the same edge when empty -> the push is accepted and the pop is ignored; count = 1.
REQ-025 Peek and pop in the same edge -> tx_data = the entry before the pop (the old head).
REQ-026 A push becomes visible to a peek on the cycle after its write edge; fifo_empty deasserts on that same cycle.
REQ-027 All flags and fifo_counter SHALL be registered and updated on the same edge as the count change, so they are mutually coherent on every cycle.
REQ-028 Pointers are FIFO_BITS wide and wrap DEPTH-1 -> 0; occupancy uses a separate FIFO_BITS+1 counter, not pointer difference.

Reset
REQ-029 While reset_n is low at an edge: pointers = 0, fifo_counter = 0, fifo_empty = 1, fifo_full = 0, fifo_half = 0, fifo_overflow = 0, tx_data = 0.
REQ-030 Memory contents are not reset; stale data SHALL never reach tx_data after reset because a peek requires fifo_empty low.
REQ-031 A reset during simultaneous push/pop takes priority; the cycle after release behaves as empty.

Structure
REQ-032 WIDTH and FIFO_BITS defaults, and the derived DEPTH constant, SHALL live in the shared larpix_pkg package.
REQ-033 Storage SHALL be one sub-module, fifo_ram: simple dual-port, one write port, one registered read port, DEPTH x WIDTH.
REQ-034 Control (pointers, counter, flags, overflow) SHALL be in shared_event_fifo and require no FSM beyond the counter.

Verification (bench also runs FIFO_BITS=3, DEPTH=8)
REQ-035 After reset, push 0xA5A5_0000_0000_0003, then peek -> tx_data = 0xA5A5_0000_0000_0003 one cycle after read_fifo_n; counter=1; empty=0.
REQ-036 DEPTH=8: 8 pushes -> full=1, half=1, counter=8; 9th push -> counter=8, overflow=1; peek/pop x8 returns values 1..8 in order, then empty=1.
REQ-037 Counter=4 with push+ack each cycle for 20 cycles -> counter stays 4; pointers wrap; data order preserved.
REQ-038 Empty FIFO with ack and read pulses -> counter=0; tx_data unchanged; no flag change.
REQ-039 Full FIFO with simultaneous push+ack -> counter=7; overflow=1; the dropped packet never appears on tx_data.
REQ-040 reset_n low for one edge mid-stream at counter=5 -> all outputs at reset values next cycle; a subsequent single push reads back correctly.

Source files
------------

// File: rtl/larpix_pkg.sv
// larpix_pkg: shared sizing defaults for the event FIFO and its storage.
package larpix_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int FIFO_BITS_DEF = 11;

    function automatic int depth_of(input int bits);
        return 1 << bits;
    endfunction

    localparam int DEPTH_DEF = depth_of(FIFO_BITS_DEF);

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port DEPTH x WIDTH storage with one write port and one registered read port.
module fifo_ram
    import larpix_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ADDR_BITS = FIFO_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [WIDTH-1:0]     rd_data_o
);

    logic [WIDTH-1:0] mem_q [depth_of(ADDR_BITS)];
    logic [WIDTH-1:0] rd_data_q;

    // The array carries no reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/shared_event_fifo.sv
// shared_event_fifo: event packet FIFO with non-destructive peek, explicit pop ack,
// registered occupancy flags and a sticky overflow indicator.
module shared_event_fifo
    import larpix_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FIFO_BITS = FIFO_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     input_event,
    input  logic                 write_fifo_n,
    input  logic                 read_fifo_n,
    input  logic                 fifo_ack,
    output logic [WIDTH-1:0]     tx_data,
    output logic                 fifo_full,
    output logic                 fifo_half,
    output logic                 fifo_empty,
    output logic [FIFO_BITS:0]   fifo_counter,
    output logic                 fifo_overflow
);

    localparam int DEPTH = depth_of(FIFO_BITS);
    localparam logic [FIFO_BITS:0] FULL_CNT = (FIFO_BITS+1)'(DEPTH);
    localparam logic [FIFO_BITS:0] HALF_CNT = (FIFO_BITS+1)'(DEPTH / 2);

    logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_BITS:0]   cnt_q, cnt_d;
    logic                 full_q, half_q, empty_q, ovf_q;
    logic                 push, pop, peek;

    // Acceptance uses the registered flags, so a full FIFO drops a push even when popped that edge.
    always_comb begin
        push     = !write_fifo_n && !full_q;
        pop      = fifo_ack && !empty_q;
        peek     = !read_fifo_n && !empty_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + {{FIFO_BITS{1'b0}}, push} - {{FIFO_BITS{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            half_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= cnt_d == FULL_CNT;
            half_q   <= cnt_d >= HALF_CNT;
            empty_q  <= cnt_d == '0;
            ovf_q    <= ovf_q || (!write_fifo_n && full_q);
        end
    end

    fifo_ram #(
        .WIDTH(WIDTH),
        .ADDR_BITS(FIFO_BITS)
    ) u_ram (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en_i(push),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(input_event),
        .rd_en_i(peek),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(tx_data)
    );

    assign fifo_full     = full_q;
    assign fifo_half     = half_q;
    assign fifo_empty    = empty_q;
    assign fifo_counter  = cnt_q;
    assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_shared_event_fifo.sv
// tb_shared_event_fifo: drives a default-size and an 8-deep FIFO with shared stimulus,
// comparing both against queue-based reference models every cycle.
module tb_shared_event_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        write_fifo_n = 1'b1;
    logic        read_fifo_n = 1'b1;
    logic        fifo_ack = 1'b0;
    logic [63:0] input_event = '0;

    logic [63:0] tx_a, tx_b;
    logic        full_a, half_a, empty_a, ovf_a;
    logic        full_b, half_b, empty_b, ovf_b;
    logic [11:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq [2][$];
    logic [63:0] mtx [2];
    logic        movf [2];
    int          dep [2] = '{2048, 8};

    always #5 clk = ~clk;

    shared_event_fifo u_a (
        .clk(clk), .reset_n(reset_n), .input_event(input_event),
        .write_fifo_n(write_fifo_n), .read_fifo_n(read_fifo_n), .fifo_ack(fifo_ack),
        .tx_data(tx_a), .fifo_full(full_a), .fifo_half(half_a), .fifo_empty(empty_a),
        .fifo_counter(cnt_a), .fifo_overflow(ovf_a)
    );

    shared_event_fifo #(.WIDTH(64), .FIFO_BITS(3)) u_b (
        .clk(clk), .reset_n(reset_n), .input_event(input_event),
        .write_fifo_n(write_fifo_n), .read_fifo_n(read_fifo_n), .fifo_ack(fifo_ack),
        .tx_data(tx_b), .fifo_full(full_b), .fifo_half(half_b), .fifo_empty(empty_b),
        .fifo_counter(cnt_b), .fifo_overflow(ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge: apply inputs, advance both reference models, then compare all outputs.
    task automatic step(input logic rn, input logic wn, input logic rdn, input logic ack, input logic [63:0] d);
        reset_n = rn;
        write_fifo_n = wn;
        read_fifo_n = rdn;
        fifo_ack = ack;
        input_event = d;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit emp;
            bit ful;
            emp = mq[k].size() == 0;
            ful = mq[k].size() == dep[k];
            if (!rn) begin
                mq[k].delete();
                mtx[k] = '0;
                movf[k] = 1'b0;
            end else begin
                if (!rdn && !emp) mtx[k] = mq[k][0];
                if (!wn && ful) movf[k] = 1'b1;
                if (ack && !emp) void'(mq[k].pop_front());
                if (!wn && !ful) mq[k].push_back(d);
            end
        end
        #1;
        check("a_tx", tx_a, mtx[0]);
        check("a_cnt", 64'(cnt_a), 64'(mq[0].size()));
        check("a_full", 64'(full_a), 64'(mq[0].size() == dep[0]));
        check("a_half", 64'(half_a), 64'(mq[0].size() >= dep[0] / 2));
        check("a_empty", 64'(empty_a), 64'(mq[0].size() == 0));
        check("a_ovf", 64'(ovf_a), 64'(movf[0]));
        check("b_tx", tx_b, mtx[1]);
        check("b_cnt", 64'(cnt_b), 64'(mq[1].size()));
        check("b_full", 64'(full_b), 64'(mq[1].size() == dep[1]));
        check("b_half", 64'(half_b), 64'(mq[1].size() >= dep[1] / 2));
        check("b_empty", 64'(empty_b), 64'(mq[1].size() == 0));
        check("b_ovf", 64'(ovf_b), 64'(movf[1]));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mtx[k] = '0;
            movf[k] = 1'b0;
        end
        do_reset();
        // single push then peek of a known pattern
        step(1'b1, 1'b0, 1'b1, 1'b0, 64'hA5A5_0000_0000_0003);
        step(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
        check("first_peek", tx_b, 64'hA5A5_0000_0000_0003);
        // fill the 8-deep FIFO, overflow it, then peek+pop to drain
        do_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 64'(i));
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, '0);
            check("drain_order", tx_b, 64'(i));
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        // steady state at count 4 with push+pop every cycle
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 64'(100 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 64'(200 + i));
        check("steady_cnt", 64'(cnt_b), 64'd4);
        // empty FIFO ignores ack and peek pulses, tx_data holds
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0);
        step(1'b1, 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, '0);
        check("empty_hold", tx_b, 64'h1234_5678_9ABC_DEF0);
        // full FIFO with simultaneous push+ack drops the push
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 64'(i));
        step(1'b1, 1'b0, 1'b1, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD);
        check("full_pushpop_cnt", 64'(cnt_b), 64'd7);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, '0);
            check("no_dropped", 64'(tx_b == 64'hDEAD_DEAD_DEAD_DEAD), 64'd0);
        end
        // reset mid-stream with push+pop asserted
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 64'(50 + i));
        step(1'b0, 1'b0, 1'b0, 1'b1, 64'h77);
        step(1'b1, 1'b0, 1'b1, 1'b0, 64'hCAFE_F00D);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("post_reset_peek", tx_a, 64'hCAFE_F00D);
        // fill and overflow the default-depth FIFO
        do_reset();
        for (int i = 0; i < 2049; i++) step(1'b1, 1'b0, 1'b1, 1'b0, {$urandom, $urandom});
        for (int i = 0; i < 2048; i++) step(1'b1, 1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        // randomized phases alternating fill-biased and drain-biased traffic
        do_reset();
        for (int p = 0; p < 16; p++) begin
            int wp;
            wp = (p % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 250; i++)
                step($urandom_range(0, 299) != 0, $urandom_range(0, 99) >= wp,
                     $urandom_range(0, 1) == 0, $urandom_range(0, 99) < 100 - wp,
                     {$urandom, $urandom});
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
